alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_pkg.sv | 50 +++++
 rtl/alu_if.sv | 25 ++
 rtl/mdu_seq.sv | 119 +++++++++++
 rtl/alu_exec.sv | 84 ++++++++
 tb/tb_alu_exec.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - funct codes, MDU state/op encodings and width defaults for alu_exec
package alu_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ALU_CTRL_W     = 6;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SLLV  = 6'b000100;
  localparam logic [5:0] F_SRLV  = 6'b000110;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_PASSB = 6'b001001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_t;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } mdu_op_t;

  function automatic logic is_signed_op(input mdu_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_if.sv
// rtl/alu_if.sv - issue/result bundle between the decode stage and alu_exec
interface alu_if #(
  parameter int DW = alu_pkg::DATA_WIDTH_DEF,
  parameter int CW = alu_pkg::ALU_CTRL_W
);
  logic          i_valid;
  logic [CW-1:0] i_alu_ctrl;
  logic [DW-1:0] i_data_a;
  logic [DW-1:0] i_data_b;
  logic [4:0]    i_shamt;
  logic [DW-1:0] o_result;
  logic          o_zero;
  logic          o_busy;
  logic          o_done;

  modport master (
    output i_valid, i_alu_ctrl, i_data_a, i_data_b, i_shamt,
    input  o_result, o_zero, o_busy, o_done
  );

  modport slave (
    input  i_valid, i_alu_ctrl, i_data_a, i_data_b, i_shamt,
    output o_result, o_zero, o_busy, o_done
  );
endinterface

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - iterative multiply (and divide under ALU_DIVIDER_EN) with HI/LO, counter and FSM
module mdu_seq import alu_pkg::*; #(
  parameter int DW = DATA_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  mdu_op_t       op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          wr_hi,
  input  logic          wr_lo,
  input  logic [DW-1:0] wr_data,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo,
  output logic          busy,
  output logic          done
);
  localparam int CNT_W = $clog2(DW);

  mdu_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [2*DW-1:0]  acc, step, prod;
  logic [DW-1:0]    opb, mag_a, mag_b, res_hi, res_lo;
  logic [DW:0]      msum;
  logic             neg_q, sgn, take;

  assign sgn   = is_signed_op(op);
  assign mag_a = (sgn && a[DW-1]) ? -a : a;
  assign mag_b = (sgn && b[DW-1]) ? -b : b;
  assign take  = start && (state != ST_RUN);
  assign busy  = (state == ST_RUN);
  assign done  = (state == ST_DONE);

  // acc holds {partial product, remaining multiplier bits}; one add-and-shift per cycle
  assign msum = {1'b0, acc[2*DW-1:DW]} + {1'b0, (acc[0] ? opb : {DW{1'b0}})};

`ifdef ALU_DIVIDER_EN
  logic          is_div, neg_r, div_zero;
  logic [DW-1:0] a_raw;
  logic [DW:0]   dshift, ddiff;

  // acc holds {partial remainder, dividend bits shifting into quotient}
  assign dshift = {acc[2*DW-1:DW], acc[DW-1]};
  assign ddiff  = dshift - {1'b0, opb};
`endif

  always_comb begin
    step   = {msum, acc[DW-1:1]};
    prod   = neg_q ? -step : step;
    res_hi = prod[2*DW-1:DW];
    res_lo = prod[DW-1:0];
`ifdef ALU_DIVIDER_EN
    if (is_div) begin
      step = ddiff[DW] ? {dshift[DW-1:0], acc[DW-2:0], 1'b0}
                       : {ddiff[DW-1:0],  acc[DW-2:0], 1'b1};
      if (div_zero) begin
        res_lo = {DW{1'b1}};
        res_hi = a_raw;
      end else begin
        res_lo = neg_q ? -step[DW-1:0] : step[DW-1:0];
        res_hi = neg_r ? -step[2*DW-1:DW] : step[2*DW-1:DW];
      end
    end
`endif
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (cnt == '0) state_nx = ST_DONE;
      ST_DONE: state_nx = start ? ST_RUN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
      opb   <= '0;
      neg_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef ALU_DIVIDER_EN
      is_div   <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
`endif
    end else begin
      state <= state_nx;
      if (take) begin
        acc   <= {{DW{1'b0}}, mag_a};
        opb   <= mag_b;
        neg_q <= sgn && (a[DW-1] ^ b[DW-1]);
        cnt   <= CNT_W'(DW - 1);
`ifdef ALU_DIVIDER_EN
        is_div   <= (op == OP_DIV) || (op == OP_DIVU);
        neg_r    <= sgn && a[DW-1];
        div_zero <= (b == '0);
        a_raw    <= a;
`endif
      end else if (state == ST_RUN) begin
        acc <= step;
        cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
      if (wr_hi && state != ST_RUN) hi <= wr_data;
      if (wr_lo && state != ST_RUN) lo <= wr_data;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - MIPS-funct ALU with HI/LO access and iterative MDU; ALU_DIVIDER_EN adds DIV/DIVU
module alu_exec import alu_pkg::*; #(
  parameter int DATA_WIDTH         = DATA_WIDTH_DEF,
  parameter int ALU_CTRL_BUS_WIDTH = ALU_CTRL_W
) (
  input logic  i_clk,
  input logic  i_reset,
  alu_if.slave bus
);
  logic [ALU_CTRL_BUS_WIDTH-1:0] ctrl;
  logic [DATA_WIDTH-1:0]         a, b, hi, lo, result;
  logic [4:0]                    sh, shv;
  logic                          iter_req, start, busy, done;
  mdu_op_t                       op;

  assign ctrl = bus.i_alu_ctrl;
  assign a    = bus.i_data_a;
  assign b    = bus.i_data_b;
  assign sh   = bus.i_shamt;
  assign shv  = a[4:0];

  always_comb begin
    iter_req = 1'b0;
    op       = OP_MULT;
    case (ctrl)
      F_MULT:  begin iter_req = 1'b1; op = OP_MULT;  end
      F_MULTU: begin iter_req = 1'b1; op = OP_MULTU; end
`ifdef ALU_DIVIDER_EN
      F_DIV:   begin iter_req = 1'b1; op = OP_DIV;   end
      F_DIVU:  begin iter_req = 1'b1; op = OP_DIVU;  end
`endif
      default: ;
    endcase
  end

  // issues arriving while the MDU runs are stalled upstream, so they must not touch state
  assign start = bus.i_valid && iter_req && !busy;

  mdu_seq #(.DW(DATA_WIDTH)) u_mdu (
    .clk     (i_clk),
    .reset   (i_reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .wr_hi   (bus.i_valid && ctrl == F_MTHI && !busy),
    .wr_lo   (bus.i_valid && ctrl == F_MTLO && !busy),
    .wr_data (a),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done)
  );

  always_comb begin
    result = '0;
    case (ctrl)
      F_ADD, F_ADDU: result = a + b;
      F_SUB, F_SUBU: result = a - b;
      F_AND:   result = a & b;
      F_OR:    result = a | b;
      F_XOR:   result = a ^ b;
      F_NOR:   result = ~(a | b);
      F_SLT:   result = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      F_SLTU:  result = {{(DATA_WIDTH-1){1'b0}}, a < b};
      F_SLL:   result = b << sh;
      F_SRL:   result = b >> sh;
      F_SRA:   result = $unsigned($signed(b) >>> sh);
      F_SLLV:  result = b << shv;
      F_SRLV:  result = b >> shv;
      F_SRAV:  result = $unsigned($signed(b) >>> shv);
      F_PASSB: result = b;
      F_MFHI:  result = hi;
      F_MFLO:  result = lo;
      default: result = '0;
    endcase
  end

  assign bus.o_result = result;
  assign bus.o_zero   = (result == '0);
  assign bus.o_busy   = busy;
  assign bus.o_done   = done;

endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - directed self-checking bench for alu_exec (DIV vectors when ALU_DIVIDER_EN)
module tb_alu_exec;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  alu_if bus ();

  alu_exec dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] s);
    bus.i_valid    = v;
    bus.i_alu_ctrl = f;
    bus.i_data_a   = a;
    bus.i_data_b   = b;
    bus.i_shamt    = s;
  endtask

  task automatic alu(input string tag, input logic [5:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] s, input logic [31:0] exp);
    @(negedge clk);
    drive(1'b1, f, a, b, s);
    #1;
    check(tag, bus.o_result, exp);
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    drive(1'b0, F_MFHI, 32'h0, 32'h0, 5'd0);
    #1 check({tag, " hi"}, bus.o_result, exp_hi);
    drive(1'b0, F_MFLO, 32'h0, 32'h0, 5'd0);
    #1 check({tag, " lo"}, bus.o_result, exp_lo);
  endtask

  task automatic run_mdu(input string tag, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    @(negedge clk);
    drive(1'b1, f, a, b, 5'd0);
    @(negedge clk);
    drive(1'b0, F_MFHI, 32'h0, 32'h0, 5'd0);
    n = 0;
    while (bus.o_busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 32'(n), 32'd32);
    check({tag, " done"}, {31'b0, bus.o_done}, 32'd1);
    read_hilo(tag, exp_hi, exp_lo);
    @(negedge clk);
    check({tag, " done_clear"}, {31'b0, bus.o_done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int seen;
    drive(1'b0, F_SLL, 32'h0, 32'h0, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst busy", {31'b0, bus.o_busy}, 32'd0);
    check("rst done", {31'b0, bus.o_done}, 32'd0);
    read_hilo("rst", 32'h0, 32'h0);

    alu("add",   F_ADD,   32'd5,        32'd7,        5'd0, 32'd12);
    alu("addu",  F_ADDU,  32'hFFFFFFFF, 32'h1,        5'd0, 32'h0);
    check("addu zero", {31'b0, bus.o_zero}, 32'd1);
    alu("sub",   F_SUB,   32'h0,        32'h1,        5'd0, 32'hFFFFFFFF);
    check("sub zero", {31'b0, bus.o_zero}, 32'd0);
    alu("subu",  F_SUBU,  32'd10,       32'd3,        5'd0, 32'd7);
    alu("and",   F_AND,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000);
    alu("or",    F_OR,    32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hFFF0FFF0);
    alu("xor",   F_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h0FF00FF0);
    alu("nor",   F_NOR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'h000F000F);
    alu("slt",   F_SLT,   32'hFFFFFFFF, 32'h1,        5'd0, 32'h1);
    alu("sltu",  F_SLTU,  32'hFFFFFFFF, 32'h1,        5'd0, 32'h0);
    alu("sll",   F_SLL,   32'h0,        32'h1,        5'd31, 32'h80000000);
    alu("srl",   F_SRL,   32'h0,        32'h80000000, 5'd4, 32'h08000000);
    alu("sra",   F_SRA,   32'h0,        32'h80000000, 5'd4, 32'hF8000000);
    alu("sllv",  F_SLLV,  32'h4,        32'h3,        5'd0, 32'h30);
    alu("srlv",  F_SRLV,  32'h24,       32'hF0000000, 5'd9, 32'h0F000000);
    alu("srav",  F_SRAV,  32'h21,       32'h80000000, 5'd0, 32'hC0000000);
    alu("passb", F_PASSB, 32'h1,        32'hDEADBEEF, 5'd0, 32'hDEADBEEF);
    alu("undef", 6'b111111, 32'h5,      32'h5,        5'd0, 32'h0);
    check("undef zero", {31'b0, bus.o_zero}, 32'd1);

    run_mdu("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_mdu("mult_min",  F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_mdu("mult_neg",  F_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);

    // reset at cycle 10 of a running MULT discards it and clears HI/LO
    @(negedge clk);
    drive(1'b1, F_MULT, 32'd7, 32'd9, 5'd0);
    @(negedge clk);
    drive(1'b0, F_MFHI, 32'h0, 32'h0, 5'd0);
    repeat (9) @(negedge clk);
    check("mid busy", {31'b0, bus.o_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstrun busy", {31'b0, bus.o_busy}, 32'd0);
    check("rstrun done", {31'b0, bus.o_done}, 32'd0);
    read_hilo("rstrun", 32'h0, 32'h0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.o_done || bus.o_busy) seen++;
    end
    check("rstrun quiet", 32'(seen), 32'd0);

    @(negedge clk);
    drive(1'b1, F_MTHI, 32'h0000AAAA, 32'h0, 5'd0);
    @(negedge clk);
    drive(1'b1, F_MTLO, 32'h00005555, 32'h0, 5'd0);
    @(negedge clk);
    read_hilo("mthilo", 32'h0000AAAA, 32'h00005555);

    // MTHI while running is ignored; MFHI in RUN sees the old value; MFLO in DONE sees the new one
    @(negedge clk);
    drive(1'b1, F_MULTU, 32'd3, 32'd4, 5'd0);
    @(negedge clk);
    drive(1'b1, F_MTHI, 32'h00001234, 32'h0, 5'd0);
    @(negedge clk);
    drive(1'b0, F_MFHI, 32'h0, 32'h0, 5'd0);
    #1 check("run mfhi", bus.o_result, 32'h0000AAAA);
    seen = 0;
    while (bus.o_busy && seen < 40) begin
      seen++;
      @(negedge clk);
    end
    check("run wait", 32'(seen), 32'd31);
    drive(1'b1, F_MFLO, 32'h0, 32'h0, 5'd0);
    #1 check("done mflo", bus.o_result, 32'd12);
    check("done flag", {31'b0, bus.o_done}, 32'd1);
    drive(1'b0, F_MFHI, 32'h0, 32'h0, 5'd0);
    #1 check("done mfhi", bus.o_result, 32'h0);

`ifdef ALU_DIVIDER_EN
    run_mdu("div_neg",  F_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_mdu("divu_zero", F_DIVU, 32'd5,       32'd0, 32'h00000005, 32'hFFFFFFFF);
`else
    alu("div_off", F_DIV, 32'd7, 32'd2, 5'd0, 32'h0);
    @(negedge clk);
    drive(1'b0, F_MFLO, 32'h0, 32'h0, 5'd0);
    #1 check("div_off busy", {31'b0, bus.o_busy}, 32'd0);
    check("div_off lo", bus.o_result, 32'd12);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
